// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg: shared state encoding and default widths for the pixel scheduler.
package mandelbrot_pkg;
    localparam int DEF_WIDTH    = 27;
    localparam int DEF_FBITS    = 23;
    localparam int PIXEL_DATA_W = 32;
    localparam int COORD_IDX_W  = 10;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;
endpackage

// File: rtl/mandelbrot_coord_stepper.sv
// mandelbrot_coord_stepper: raster x/y, complex coordinate and framebuffer address walker.
module mandelbrot_coord_stepper import mandelbrot_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   advance,
    input  logic [WIDTH-1:0]       x_min,
    input  logic [WIDTH-1:0]       y_max,
    input  logic [WIDTH-1:0]       step,
    output logic [COORD_IDX_W-1:0] x,
    output logic [COORD_IDX_W-1:0] y,
    output logic [WIDTH-1:0]       re,
    output logic [WIDTH-1:0]       im,
    output logic [ADDR_W-1:0]      addr,
    output logic                   last
);
    logic [WIDTH-1:0] x_min_q, step_q;
    logic x_end, y_end;
    assign x_end = x == COORD_IDX_W'(H_RES - 1);
    assign y_end = y == COORD_IDX_W'(V_RES - 1);
    assign last  = x_end && y_end;
    // advance is never issued on the last pixel, so y cannot run past V_RES-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_min_q <= '0;
            step_q  <= '0;
            x       <= '0;
            y       <= '0;
            re      <= '0;
            im      <= '0;
            addr    <= '0;
        end else if (load) begin
            x_min_q <= x_min;
            step_q  <= step;
            x       <= '0;
            y       <= '0;
            re      <= x_min;
            im      <= y_max;
            addr    <= '0;
        end else if (advance) begin
            addr <= addr + 1'b1;
            x    <= x_end ? '0 : x + 1'b1;
            y    <= x_end ? y + 1'b1 : y;
            re   <= x_end ? x_min_q : re + step_q;
            im   <= x_end ? im - step_q : im;
        end
    end
endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// mandelbrot_pixel_scheduler: issues raster-order jobs to mandelbrot_core and writes results out.
// MANDELBROT_SCHED_PERF_EN adds a saturating frame_cycles counter output.
module mandelbrot_pixel_scheduler import mandelbrot_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FBITS  = DEF_FBITS,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    frame_abort,
    input  logic [WIDTH-1:0]        x_min,
    input  logic [WIDTH-1:0]        y_max,
    input  logic [WIDTH-1:0]        step,
    output logic                    core_start,
    output logic [COORD_IDX_W-1:0]  core_pixel_x,
    output logic [COORD_IDX_W-1:0]  core_pixel_y,
    output logic [WIDTH-1:0]        core_real,
    output logic [WIDTH-1:0]        core_imag,
    input  logic                    core_busy,
    input  logic                    core_done,
    input  logic [PIXEL_DATA_W-1:0] core_pixel_data,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [PIXEL_DATA_W-1:0] wr_data,
    output logic                    frame_busy,
    output logic                    frame_done
`ifdef MANDELBROT_SCHED_PERF_EN
    ,
    output logic [31:0]             frame_cycles
`endif
);
    if (FBITS >= WIDTH || (H_RES * V_RES - 1) >= (1 << ADDR_W)) begin : g_cfg_err
        $error("mandelbrot_pixel_scheduler: FBITS or ADDR_W out of range");
    end
    state_t state;
    logic load, advance, last;
    assign load    = state == IDLE && frame_start;
    assign advance = state == WRITE && wr_ready && !frame_abort && !last;
    mandelbrot_coord_stepper #(.WIDTH(WIDTH), .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_stepper (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .advance(advance),
        .x_min(x_min),
        .y_max(y_max),
        .step(step),
        .x(core_pixel_x),
        .y(core_pixel_y),
        .re(core_real),
        .im(core_imag),
        .addr(wr_addr),
        .last(last)
    );
    // abort outranks every in-state transition; core_done outside WAIT is never looked at
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            core_start <= 1'b0;
            wr_valid   <= 1'b0;
            wr_data    <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            core_start <= 1'b0;
            frame_done <= 1'b0;
            if (frame_abort && state != IDLE) begin
                state      <= IDLE;
                wr_valid   <= 1'b0;
                frame_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (frame_start) begin
                        frame_busy <= 1'b1;
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                    ISSUE: state <= WAIT;
                    WAIT: if (core_done && !core_busy) begin
                        wr_data  <= core_pixel_data;
                        wr_valid <= 1'b1;
                        state    <= WRITE;
                    end
                    WRITE: if (wr_ready) begin
                        wr_valid   <= 1'b0;
                        frame_done <= last;
                        frame_busy <= !last;
                        core_start <= !last;
                        state      <= last ? IDLE : ISSUE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`ifdef MANDELBROT_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cycles <= '0;
        else if (load)
            frame_cycles <= '0;
        else if (frame_busy && frame_cycles != '1)
            frame_cycles <= frame_cycles + 1'b1;
    end
`endif
endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// tb_mandelbrot_pixel_scheduler: scoreboard bench with a 3-cycle core model on a 4x2 frame.
module tb_mandelbrot_pixel_scheduler;
    localparam int W = 27, H = 4, V = 2, AW = 19;
    localparam logic [W-1:0] X_MIN = 27'h7000000, Y_MAX = 27'h0800000, STEP = 27'h0400000;
    logic clk = 0, rst_n = 1, frame_start = 0, frame_abort = 0;
    logic [W-1:0] x_min = X_MIN, y_max = Y_MAX, step = STEP;
    logic core_start;
    logic [9:0] core_pixel_x, core_pixel_y;
    logic [W-1:0] core_real, core_imag;
    logic core_busy = 0, core_done = 0;
    logic [31:0] core_pixel_data = 0;
    logic wr_valid, wr_ready = 0;
    logic [AW-1:0] wr_addr;
    logic [31:0] wr_data;
    logic frame_busy, frame_done;
`ifdef MANDELBROT_SCHED_PERF_EN
    logic [31:0] frame_cycles;
`endif
    int vectors = 0, miscompares = 0;
    int wr_count = 0, done_cnt = 0, pix = 0, pending = 0, stall_cnt = 0, ready_mode = 0, busy_cycles = 0;
    logic busy_prev = 0;
    logic [W-1:0] er, ei;
    logic [AW-1:0] addr_q[$];
    logic [31:0] data_q[$];

    mandelbrot_pixel_scheduler #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_abort(frame_abort),
        .x_min(x_min), .y_max(y_max), .step(step),
        .core_start(core_start), .core_pixel_x(core_pixel_x), .core_pixel_y(core_pixel_y),
        .core_real(core_real), .core_imag(core_imag),
        .core_busy(core_busy), .core_done(core_done), .core_pixel_data(core_pixel_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_busy(frame_busy), .frame_done(frame_done)
`ifdef MANDELBROT_SCHED_PERF_EN
        , .frame_cycles(frame_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // core model, write sink and scoreboard, all evaluated on the falling edge
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pending = 0;
            core_done = 0;
            core_busy = 0;
        end else begin
            wr_ready = ready_mode == 0 ? 1'b1 :
                       ready_mode == 2 ? (wr_addr != 1) : !(wr_valid && wr_addr == 2 && stall_cnt < 5);
            if (ready_mode == 1 && !wr_ready) stall_cnt++;
            if (!frame_busy) begin
                pix = 0;
                stall_cnt = 0;
                addr_q.delete();
                data_q.delete();
            end
            if (frame_busy && !busy_prev) busy_cycles = 0;
            if (frame_busy) busy_cycles++;
            busy_prev = frame_busy;
            if (frame_done) done_cnt++;
            core_done = 0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    core_done = 1;
                    core_busy = 0;
                    core_pixel_data = $urandom;
                    if (frame_busy) data_q.push_back(core_pixel_data);
                end
            end
            if (core_start) begin
                er = X_MIN + W'(STEP * (pix % H));
                ei = Y_MAX - W'(STEP * (pix / H));
                check("pix_x", core_pixel_x, pix % H);
                check("pix_y", core_pixel_y, pix / H);
                check("real", core_real, er);
                check("imag", core_imag, ei);
                addr_q.push_back(AW'((pix / H) * H + pix % H));
                pix++;
                pending = 3;
                core_busy = 1;
            end
            if (wr_valid && wr_ready) begin
                wr_count++;
                check("sb_underflow", addr_q.size() == 0 || data_q.size() == 0, 0);
                if (addr_q.size() > 0 && data_q.size() > 0) begin
                    check("wr_addr", wr_addr, addr_q.pop_front());
                    check("wr_data", wr_data, data_q.pop_front());
                end
            end else if (wr_valid && addr_q.size() > 0 && data_q.size() > 0) begin
                check("stall_start", core_start, 0);
                check("stall_addr", wr_addr, addr_q[0]);
                check("stall_data", wr_data, data_q[0]);
            end
        end
    end

    task automatic run_frame(input bit poke);
        int w0, d0;
        w0 = wr_count;
        d0 = done_cnt;
        @(negedge clk); frame_start = 1;
        @(negedge clk); frame_start = 0;
        check("start_latency", core_start, 1);
        check("busy_on", frame_busy, 1);
        if (poke) begin
            repeat (4) @(negedge clk);
            frame_start = 1;
            @(negedge clk); frame_start = 0;
        end
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
        @(negedge clk);
        check("frame_done_cnt", done_cnt - d0, 1);
        check("write_cnt", wr_count - w0, H * V);
        check("busy_off", frame_busy, 0);
`ifdef MANDELBROT_SCHED_PERF_EN
        check("frame_cycles", frame_cycles, busy_cycles);
        repeat (3) @(negedge clk);
        check("frame_cycles_hold", frame_cycles, busy_cycles);
`endif
    endtask

    initial begin
        int w0, d0;
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        check("rst_core_start", core_start, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_frame_busy", frame_busy, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_core_real", core_real, 0);
        rst_n = 1;
        ready_mode = 1;
        run_frame(1);
        ready_mode = 0;
        w0 = wr_count;
        d0 = done_cnt;
        @(negedge clk); frame_start = 1;
        @(negedge clk); frame_start = 0;
        for (int i = 0; i < 200 && !(core_start && core_pixel_x == 3); i++) @(negedge clk);
        @(negedge clk); frame_abort = 1;
        @(negedge clk); frame_abort = 0;
        check("abort_busy", frame_busy, 0);
        check("abort_valid", wr_valid, 0);
        repeat (6) @(negedge clk);
        check("abort_writes", wr_count - w0, 3);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_valid", wr_valid, 0);
        run_frame(0);
        ready_mode = 2;
        @(negedge clk); frame_start = 1;
        @(negedge clk); frame_start = 0;
        for (int i = 0; i < 200 && !(wr_valid && wr_addr == 1); i++) @(negedge clk);
        check("reach_write", wr_valid, 1);
        #2 rst_n = 0;
        #1;
        check("arst_wr_valid", wr_valid, 0);
        check("arst_frame_busy", frame_busy, 0);
        check("arst_wr_addr", wr_addr, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_core_real", core_real, 0);
        check("arst_core_imag", core_imag, 0);
        check("arst_pix_x", core_pixel_x, 0);
        check("arst_core_start", core_start, 0);
        @(negedge clk);
        rst_n = 1;
        ready_mode = 0;
        run_frame(0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
